// File: rtl/fetch_decode_buffer_pkg.sv
// Shared ISA definitions for the fetch/decode buffer: widths, opcode field, opcodes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_decode_buffer_pkg;

  localparam int XLEN   = 32;
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 25;
  localparam int OPC_W  = OPC_HI - OPC_LO + 1;

  localparam logic [OPC_W-1:0] OP_B   = 7'b1100000;
  localparam logic [OPC_W-1:0] OP_NOP = 7'b1100100;

  // One buffered fetch slot; 64 bits wide.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [XLEN-1:0] instr);
    return instr[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/fetch_decode_buffer_entry_ram.sv
// Entry storage: DEPTH x 64-bit, one synchronous write port, one async read port.
// Latency: write visible on read port the cycle after the write edge.
// Backpressure: none; the controller decides when to write.
module fdb_entry_ram
  import fetch_decode_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  entry_t        wdata,
  input  logic [AW-1:0] raddr,
  output entry_t        rdata
);

  entry_t mem [DEPTH];

  // Storage is not reset; validity is tracked by the controller's count.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_decode_buffer.sv
// Fetch-to-decode FIFO with NOP filtering at write and single-cycle flush.
// Latency: a pushed entry reaches out_* one cycle after its push edge (no bypass).
// Backpressure: in_ready = (count < DEPTH), registered state only; out_* held while !out_ready.
module fetch_decode_buffer
  import fetch_decode_buffer_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int DROP_NOP = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_instr,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_instr,
  output logic [OPC_W-1:0]         out_opcode,
  output logic                     out_is_branch,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] occ;
  logic          in_nop;
  logic          push_hs;
  logic          store;
  logic          drop;
  logic          pop;
  entry_t        wr_entry;
  entry_t        rd_entry;

  // Handshake qualification: flush cancels both sides; NOPs complete the
  // handshake but never take a slot.
  assign in_ready  = (occ < CW'(DEPTH));
  assign out_valid = (occ != '0);
  assign in_nop    = (DROP_NOP != 0) && (opcode_of(in_instr) == OP_NOP);
  assign push_hs   = in_valid && in_ready && !flush;
  assign store     = push_hs && !in_nop;
  assign drop      = push_hs && in_nop;
  assign pop       = out_valid && out_ready && !flush;

  assign wr_entry  = '{pc: in_pc, instr: in_instr};

  fdb_entry_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (store),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  // Pointer and occupancy tracking; pointers wrap naturally at power-of-two DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      occ    <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({store, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Saturating dropped-NOP counter; survives flush, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Head presentation: forced to zero when empty so stale storage never leaks.
  always_comb begin
    out_pc        = '0;
    out_instr     = '0;
    if (out_valid) begin
      out_pc      = rd_entry.pc;
      out_instr   = rd_entry.instr;
    end
    out_opcode    = opcode_of(out_instr);
    out_is_branch = out_valid && (out_opcode == OP_B);
  end

  assign count = occ;

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Scoreboard bench for fetch_decode_buffer: directed scenarios then random traffic.
// Expected entries are queued when stimulus is issued; a negedge monitor compares.
// Model is a plain queue with occupancy limit, NOP filter and flush/reset clearing.
module tb_fetch_decode_buffer;
  import fetch_decode_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [6:0]  out_opcode;
  logic        out_is_branch;
  logic [2:0]  count;
  logic [15:0] drop_cnt;

  fetch_decode_buffer #(.DEPTH(DEPTH), .DROP_NOP(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_pc         (in_pc),
    .in_instr      (in_instr),
    .in_ready      (in_ready),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .out_opcode    (out_opcode),
    .out_is_branch (out_is_branch),
    .count         (count),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  entry_t exp_q[$];
  int     exp_drops = 0;
  bit     model_ok  = 1'b0;
  int     n_cmp = 0;
  int     n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus, then advance the reference queue at the edge.
  task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] instr,
                      input bit rdy, input bit fl, input bit r);
    bit take_in;
    bit take_out;
    bit is_nop;
    in_valid  = v;
    in_pc     = pc;
    in_instr  = instr;
    out_ready = rdy;
    flush     = fl;
    rst       = r;
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      exp_drops = 0;
      model_ok  = 1'b1;
    end else if (fl) begin
      exp_q.delete();
    end else begin
      is_nop   = (instr[31:25] == 7'b1100100);
      take_in  = v && (exp_q.size() < DEPTH);
      take_out = rdy && (exp_q.size() > 0);
      if (take_out) void'(exp_q.pop_front());
      if (take_in && is_nop) begin
        if (exp_drops < 65535) exp_drops++;
      end else if (take_in) begin
        exp_q.push_back('{pc: pc, instr: instr});
      end
    end
    #2;
  endtask

  // Monitor: compare every observable output against the reference each cycle.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("count", 64'(count), 64'(exp_q.size()));
      chk("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      chk("drop_cnt", 64'(drop_cnt), 64'(exp_drops));
      if (exp_q.size() != 0) begin
        chk("out_pc", 64'(out_pc), 64'(exp_q[0].pc));
        chk("out_instr", 64'(out_instr), 64'(exp_q[0].instr));
        chk("out_opcode", 64'(out_opcode), 64'(exp_q[0].instr[31:25]));
        chk("out_is_branch", 64'(out_is_branch), 64'(exp_q[0].instr[31:25] == 7'b1100000));
      end else begin
        chk("empty_pc", 64'(out_pc), 64'd0);
        chk("empty_instr", 64'(out_instr), 64'd0);
        chk("empty_branch", 64'(out_is_branch), 64'd0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] ADD = 32'h0000_0013;
  localparam logic [31:0] NOP = 32'hC800_0000;
  localparam logic [31:0] BR  = 32'hC000_0040;

  initial begin
    logic [31:0] pc;
    logic [31:0] ins;
    bit v, rdy, fl, r;

    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);

    // Fill to DEPTH with decode stalled; fifth push must be refused.
    for (int i = 0; i < 5; i++) step(1, 32'(i * 4), ADD + 32'(i), 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // Drain in order, then observe empty.
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0);

    // Concurrent push/pop at count=2, with a branch in the mix.
    step(1, 32'h10, ADD, 0, 0, 0);
    step(1, 32'h14, BR, 0, 0, 0);
    step(1, 32'h20, ADD, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);

    // NOP drop on an empty buffer and on a non-empty one.
    step(1, 32'h30, NOP, 0, 0, 0);
    step(1, 32'h34, ADD, 0, 0, 0);
    step(1, 32'h38, NOP, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Flush at count=3 with a concurrent push; then flush while empty.
    for (int i = 0; i < 3; i++) step(1, 32'h40 + 32'(i * 4), ADD, 0, 0, 0);
    step(1, 32'h4C, ADD, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0);

    // Wrap pointers with push/pop pairs, then reset together with flush.
    step(1, 32'h100, ADD, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 32'h104 + 32'(i * 4), ADD + 32'(i), 1, 0, 0);
    step(1, 32'h200, ADD, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Random traffic.
    pc = 32'h1000;
    for (int i = 0; i < 1500; i++) begin
      v   = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 1) == 1);
      fl  = ($urandom_range(0, 39) == 0);
      r   = ($urandom_range(0, 299) == 0);
      ins = $urandom;
      case ($urandom_range(0, 4))
        0: ins[31:25] = 7'b1100100;
        1: ins[31:25] = 7'b1100000;
        default: ;
      endcase
      step(v, pc, ins, rdy, fl, r);
      pc = pc + 32'd4;
    end
    step(0, 0, 0, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_decode_buffer.md
FETCH_DECODE_BUFFER -- requirements
Module: fetch_decode_buffer

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, meaning number of {pc,instr} entries; legal values are powers of two, 2..16.
REQ-002 SHALL provide parameter DROP_NOP, default 1, meaning NOP-opcode instructions are discarded at write when 1.
REQ-003 SHALL use clock clk and reset rst; rst is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  fetch presents a valid {in_pc,in_instr}.
REQ-007 in_pc  input  32  program counter of the fetched instruction.
REQ-008 in_instr  input  32  filtered instruction from fetch.
REQ-009 in_ready  output  1  buffer accepts a write this cycle.
REQ-010 flush  input  1  branch/override redirect; discard all contents.
REQ-011 out_valid  output  1  head entry valid for decode.
REQ-012 out_ready  input  1  decode consumes head this cycle.
REQ-013 out_pc  output  32  head entry PC.
REQ-014 out_instr  output  32  head entry instruction.
REQ-015 out_opcode  output  7  out_instr[31:25].
REQ-016 out_is_branch  output  1  head opcode == 7'b1100000 (B).
REQ-017 count  output  $clog2(DEPTH)+1  occupied entries.
REQ-018 drop_cnt  output  16  saturating count of dropped NOPs.

Function
REQ-019 Push SHALL occur when in_valid && in_ready && !flush; pop SHALL occur when out_valid && out_ready && !flush.
REQ-020 in_ready SHALL equal (count < DEPTH); no combinational path from out_ready to in_ready.
REQ-021 A pushed entry SHALL appear at out_* with out_valid=1 exactly one cycle after the push edge (no same-cycle bypass).
REQ-022 When empty, out_valid SHALL be 0 and out_pc, out_instr, out_is_branch SHALL be 0.
REQ-023 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor underflow.
REQ-025 With DROP_NOP=1, a handshaked input with in_instr[31:25]==7'b1100100 SHALL not be stored, SHALL still complete the handshake, and SHALL increment drop_cnt (saturating at 16'hFFFF).
REQ-026 flush SHALL on the next edge set count=0, equalize pointers, and clear out_valid; any push or pop in the flush cycle SHALL be ignored.
REQ-027 flush while empty SHALL be harmless; drop_cnt SHALL not be cleared by flush.
REQ-028 Entries SHALL be held stable at out_* while out_valid && !out_ready.

Reset
REQ-029 On rst: pointers=0, count=0, out_valid=0, drop_cnt=0, out_pc=out_instr=0; storage contents need not be cleared.
REQ-030 rst SHALL take priority over flush, push and pop in the same cycle.
REQ-031 rst asserted mid-operation SHALL discard all entries; in_ready SHALL be 1 the cycle after rst deasserts.

Structure
REQ-032 Opcode constants (OP_B=7'b1100000, OP_NOP=7'b1100100), instruction/PC width 32 and opcode field bounds SHALL live in the shared ISA package.
REQ-033 Storage SHALL be a sub-module fdb_entry_ram (DEPTH x 64-bit, one write port, one async read port); pointer/count control stays in the top.

Verification
REQ-034 Fill: 4 pushes (pc 0,4,8,12) with out_ready=0 -> count=4, in_ready=0, out_pc=0 held; 5th push ignored.
REQ-035 Drain order: then out_ready=1 for 4 cycles -> out_pc 0,4,8,12 in order, then out_valid=0, out_instr=0.
REQ-036 Concurrent: count=2, push pc 0x20 and pop same cycle -> count stays 2, 0x20 emerges after the two older entries.
REQ-037 NOP drop: push instr 0xC8000000 -> count unchanged, drop_cnt=1, in_ready remained 1.
REQ-038 Flush: count=3, flush with in_valid=1 -> next cycle count=0, out_valid=0, pushed entry absent.
REQ-039 Reset/wrap: 10 push/pop pairs across wrap then rst with flush=1 -> count=0, drop_cnt=0, in_ready=1 after release.
